// File: rtl/pipelined_kpg_adder.sv
// ---------------------------------------------------------------------------
// pipelined_kpg_adder
//
// Kogge-Stone prefix adder/subtractor over a kill/propagate/generate (kpg)
// carry vector, cut into N = ceil(L/LPS) register stages with L = log2(WIDTH)+1
// prefix levels. Each stage carries a valid bit and uses valid/ready flow
// control, so the pipeline can stall at any point without losing beats.
//
// Parameters
//   WIDTH  operand width (power of two, 8..128)
//   LPS    prefix levels evaluated per register stage (1..L)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears stage valid bits)
//   in_valid   operand beat offered          in_ready   beat accepted this cycle
//   a, b       operands                      cin        carry in (ignored when sub=1)
//   sub        0: a+b+cin, 1: a-b            flush      synchronous pipeline clear
//   out_valid  result beat present           out_ready  consumer accepts result
//   sum        result bits                   cout       carry out of bit WIDTH-1
//   ovf        signed overflow of the selected operation
// ---------------------------------------------------------------------------
module pipelined_kpg_adder #(
   parameter int WIDTH = 64,
   parameter int LPS   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int L = $clog2(WIDTH) + 1;
   localparam int N = (L + LPS - 1) / LPS;

   localparam logic [1:0] KPG_K = 2'b00;
   localparam logic [1:0] KPG_P = 2'b01;
   localparam logic [1:0] KPG_G = 2'b10;

   // Element 0 is the carry-in; element i+1 describes operand bit i.
   typedef logic [WIDTH:0][1:0] vec_t;

   // One Kogge-Stone level at distance 2^j: a propagate element inherits the
   // element 2^j positions below it; kill/generate are already resolved.
   function automatic vec_t ks_level(input vec_t v, input int j);
      vec_t r;
      int   d;
      d = 1 << j;
      r = v;
      for (int i = 0; i <= WIDTH; i++) begin
         if (i >= d && v[i] == KPG_P) begin
            r[i] = v[i - d];
         end
      end
      return r;
   endfunction

   logic [WIDTH-1:0] b_eff;
   logic             c_eff;
   vec_t             in_vec;

   always_comb begin
      b_eff     = sub ? ~b : b;
      c_eff     = sub | cin;
      in_vec    = '0;
      in_vec[0] = c_eff ? KPG_G : KPG_K;
      for (int i = 0; i < WIDTH; i++) begin
         in_vec[i+1] = {a[i] & b_eff[i], a[i] ^ b_eff[i]};
      end
   end

   logic [N-1:0] valid_vec;
   logic [N-1:0] load;

   // A stage may load when it, or any stage after it, is empty, or when the
   // consumer takes the final result; this is the ripple of "next stage loads".
   always_comb begin
      logic chain;
      load  = '0;
      chain = out_ready;
      for (int s = N - 1; s >= 0; s--) begin
         chain   = chain | ~valid_vec[s];
         load[s] = chain;
      end
   end

   // rst_n gates in_ready so nothing is advertised while reset is held.
   assign in_ready = rst_n & ~flush & load[0];

   genvar gi;
   for (gi = 0; gi < N; gi++) begin : g_stage
      vec_t             src_vec;
      vec_t             lvl_vec;
      vec_t             kpg_reg;
      logic [WIDTH-1:0] src_xor;
      logic [WIDTH-1:0] xor_reg;
      logic             src_am;
      logic             src_bm;
      logic             src_valid;
      logic             am_reg;
      logic             bm_reg;
      logic             valid_reg;

      if (gi == 0) begin : g_first
         assign src_vec   = in_vec;
         assign src_xor   = a ^ b_eff;
         assign src_am    = a[WIDTH-1];
         assign src_bm    = b_eff[WIDTH-1];
         assign src_valid = in_valid;
      end else begin : g_next
         assign src_vec   = g_stage[gi-1].kpg_reg;
         assign src_xor   = g_stage[gi-1].xor_reg;
         assign src_am    = g_stage[gi-1].am_reg;
         assign src_bm    = g_stage[gi-1].bm_reg;
         assign src_valid = g_stage[gi-1].valid_reg;
      end

      // Levels gi*LPS .. gi*LPS+LPS-1; the last stage stops at level L-1.
      always_comb begin
         lvl_vec = src_vec;
         for (int k = 0; k < LPS; k++) begin
            if (gi * LPS + k < L) begin
               lvl_vec = ks_level(lvl_vec, gi * LPS + k);
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_reg <= 1'b0;
         end else if (flush) begin
            valid_reg <= 1'b0;
         end else if (load[gi]) begin
            valid_reg <= src_valid;
         end
      end

      // Payload is only meaningful alongside valid_reg, so it needs no reset.
      always_ff @(posedge clk) begin
         if (load[gi]) begin
            kpg_reg <= lvl_vec;
            xor_reg <= src_xor;
            am_reg  <= src_am;
            bm_reg  <= src_bm;
         end
      end

      assign valid_vec[gi] = valid_reg;
   end

   vec_t             res_vec;
   logic [WIDTH-1:0] res_xor;
   logic [WIDTH-1:0] sum_raw;
   logic             res_am;
   logic             res_bm;

   assign res_vec = g_stage[N-1].kpg_reg;
   assign res_xor = g_stage[N-1].xor_reg;
   assign res_am  = g_stage[N-1].am_reg;
   assign res_bm  = g_stage[N-1].bm_reg;

   // Resolved element i is the carry into bit i.
   always_comb begin
      sum_raw = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum_raw[i] = res_xor[i] ^ (res_vec[i] == KPG_G);
      end
   end

   // Outputs are masked by out_valid so they read as zero whenever the last
   // stage is empty, including throughout reset.
   assign out_valid = valid_vec[N-1];
   assign sum       = out_valid ? sum_raw : '0;
   assign cout      = out_valid & (res_vec[WIDTH] == KPG_G);
   assign ovf       = out_valid & (res_am == res_bm) & (sum_raw[WIDTH-1] != res_am);

endmodule

// File: tb/tb_pipelined_kpg_adder.sv
module tb_pipelined_kpg_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, cin, sub, flush, out_valid, out_ready, cout, ovf;
   logic [63:0] a, b, sum;

   // Secondary configurations: 8/4 (N=1), 128/3 (N=3), 64/7 (N=1)
   logic         x_valid;
   logic         rdy8, ov8, co8, of8;
   logic         rdy128, ov128, co128, of128;
   logic         rdy7, ov7, co7, of7;
   logic [7:0]   a8, b8, s8;
   logic [127:0] a128, b128, s128;
   logic [63:0]  a7, b7, s7;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   pipelined_kpg_adder #(.WIDTH(64), .LPS(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

   pipelined_kpg_adder #(.WIDTH(8), .LPS(4)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(rdy8),
      .a(a8), .b(b8), .cin(1'b1), .sub(1'b0), .flush(flush),
      .out_valid(ov8), .out_ready(1'b1), .sum(s8), .cout(co8), .ovf(of8));

   pipelined_kpg_adder #(.WIDTH(128), .LPS(3)) u_w128 (
      .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(rdy128),
      .a(a128), .b(b128), .cin(1'b1), .sub(1'b0), .flush(flush),
      .out_valid(ov128), .out_ready(1'b1), .sum(s128), .cout(co128), .ovf(of128));

   pipelined_kpg_adder #(.WIDTH(64), .LPS(7)) u_l7 (
      .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(rdy7),
      .a(a7), .b(b7), .cin(1'b1), .sub(1'b0), .flush(flush),
      .out_valid(ov7), .out_ready(1'b1), .sum(s7), .cout(co7), .ovf(of7));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic. Returns {ovf, cout, sum}.
   function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                         input logic ci, input logic s);
      logic [64:0] full;
      logic [65:0] ext;
      logic        co;
      if (s) begin
         full = {1'b0, x} - {1'b0, y};
         co   = (x >= y);
         ext  = {{2{x[63]}}, x} - {{2{y[63]}}, y};
      end else begin
         full = {1'b0, x} + {1'b0, y} + {64'd0, ci};
         co   = full[64];
         ext  = {{2{x[63]}}, x} + {{2{y[63]}}, y} + {65'd0, ci};
      end
      return {ext[65:63] != {3{ext[63]}}, co, full[63:0]};
   endfunction

   function automatic logic [63:0] rnd64();
      case ($urandom_range(0, 7))
         0: return '1;
         1: return '0;
         2: return 64'h8000_0000_0000_0000;
         3: return 64'h7FFF_FFFF_FFFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        sub;
      logic [63:0] s;
      logic        co;
      logic        ov;
   } vec_rec_t;

   vec_rec_t tbl [8];

   initial begin
      int          lat, got, sent, seen, l8, l128, l7;
      logic [65:0] q[$];
      logic [65:0] held, exp_r;
      logic        stalled;

      tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
      tbl[1] = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
      tbl[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      tbl[4] = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0};
      tbl[5] = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0};
      tbl[6] = '{64'h1234, 64'h4321, 1'b0, 1'b0, 64'h5555, 1'b0, 1'b0};
      tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      flush = 1'b0; out_ready = 1'b1; x_valid = 1'b0;
      a8 = '1; b8 = '1; a128 = '1; b128 = '1; a7 = '1; b7 = '1;

      // Reset state
      step(); step();
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_in_ready", 128'(in_ready), 128'd0);
      check("rst_outputs", 128'({ovf, cout, sum}), 128'd0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", 128'(in_ready), 128'd1);

      // Latency of the short/long configurations, all-ones + all-ones + 1
      check("w8_ready", 128'(rdy8), 128'd1);
      check("w128_ready", 128'(rdy128), 128'd1);
      check("l7_ready", 128'(rdy7), 128'd1);
      x_valid = 1'b1;
      step();
      x_valid = 1'b0;
      l8 = 0; l128 = 0; l7 = 0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         if (ov8 && l8 == 0) begin
            l8 = cyc;
            check("w8_result", 128'({of8, co8, s8}), 128'({1'b0, 1'b1, 8'hFF}));
         end
         if (ov128 && l128 == 0) begin
            l128 = cyc;
            check("w128_result", {s128}, '1);
            check("w128_flags", 128'({of128, co128}), 128'b01);
         end
         if (ov7 && l7 == 0) begin
            l7 = cyc;
            check("l7_result", 128'({of7, co7, s7}), 128'({1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF}));
         end
         step();
      end
      check("w8_latency", 128'(l8), 128'd1);
      check("w128_latency", 128'(l128), 128'd3);
      check("l7_latency", 128'(l7), 128'd1);

      // Directed vectors, one at a time, latency 7
      for (int i = 0; i < 8; i++) begin
         a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub;
         in_valid = 1'b1; out_ready = 1'b1;
         #1;
         check("vec_in_ready", 128'(in_ready), 128'd1);
         step();
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 20) begin
            step();
            lat++;
         end
         $display("vec %0d a=%h b=%h sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                  i, tbl[i].a, tbl[i].b, tbl[i].sub, sum, cout, ovf, lat);
         check("vec_latency", 128'(lat), 128'd7);
         check("vec_sum", 128'(sum), 128'(tbl[i].s));
         check("vec_cout", 128'(cout), 128'(tbl[i].co));
         check("vec_ovf", 128'(ovf), 128'(tbl[i].ov));
         step();
      end

      // Random stream with random backpressure
      sent = 0; got = 0; stalled = 1'b0; held = '0;
      for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
         if (stalled) begin
            check("stall_valid", 128'(out_valid), 128'd1);
            check("stall_hold", 128'({ovf, cout, sum}), 128'(held));
         end
         in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
         a = rnd64(); b = rnd64();
         cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, cin, sub));
            sent++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("stream_extra", 128'(got), 128'(sent));
            end else begin
               exp_r = q.pop_front();
               $display("beat %0d sum=%h cout=%0d ovf=%0d", got, sum, cout, ovf);
               check("stream_beat", 128'({ovf, cout, sum}), 128'(exp_r));
            end
            got++;
         end
         stalled = out_valid && !out_ready;
         held    = {ovf, cout, sum};
         step();
      end
      in_valid = 1'b0;
      check("stream_count", 128'(got), 128'd100);
      check("stream_sent", 128'(sent), 128'd100);

      // Flush with four beats in flight
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      for (int i = 0; i < 4; i++) begin
         a = rnd64(); b = rnd64(); in_valid = 1'b1;
         step();
      end
      flush = 1'b1;
      #1;
      check("flush_in_ready", 128'(in_ready), 128'd0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", 128'(out_valid), 128'd0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) seen++;
         step();
      end
      check("flush_no_emit", 128'(seen), 128'd0);

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         a = rnd64(); b = rnd64(); in_valid = 1'b1;
         step();
      end
      check("pre_rst_valid", 128'(out_valid), 128'd1);
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 128'(out_valid), 128'd0);
      check("arst_in_ready", 128'(in_ready), 128'd0);
      check("arst_outputs", 128'({ovf, cout, sum}), 128'd0);
      in_valid = 1'b0;
      step(); step();
      rst_n = 1'b1;
      #1;
      check("rst_release_ready", 128'(in_ready), 128'd1);
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid) seen++;
         step();
      end
      check("rst_discard", 128'(seen), 128'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
